// File: rtl/single_cycle_cpu_top.sv
//==============================================================================
// Module  : single_cycle_cpu_top
// Brief   : Single-cycle 32-bit MIPS-subset CPU; optional jal/jr via JUMP_LINK_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module single_cycle_cpu_imem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [31:0]   i_wdata,
    input  wire logic [AW-1:0] i_raddr,
    output logic      [31:0]   o_rdata
);
    logic [31:0] mem [DEPTH];

    // In-system program load port; idle when the image is preloaded.
    always_ff @(posedge clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = mem[i_raddr];
endmodule

module single_cycle_cpu_regfile (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [4:0]  i_ra1,
    input  wire logic [4:0]  i_ra2,
    input  wire logic        i_we,
    input  wire logic [4:0]  i_wa,
    input  wire logic [31:0] i_wd,
    output logic      [31:0] o_rd1,
    output logic      [31:0] o_rd2
);
    logic [31:0] gpr [32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
        end else if (i_we && (i_wa != 5'd0)) begin
            gpr[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : gpr[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : gpr[i_ra2];
endmodule

module single_cycle_cpu_dmem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_we,
    input  wire logic [31:0] i_addr,
    input  wire logic [31:0] i_wdata,
    output logic      [31:0] o_rdata
);
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] w_idx;
    logic          w_unused_addr_bits;

    // Byte offset is ignored and upper bits wrap modulo the depth.
    assign w_idx              = i_addr[AW+1:2];
    assign w_unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
        end else if (i_we) begin
            mem[w_idx] <= i_wdata;
        end
    end

    assign o_rdata = mem[w_idx];
endmodule

module single_cycle_cpu_top #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
    input wire logic clk,
    input wire logic rst_n
);
    localparam int c_IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int c_DMEM_AW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    logic [31:0] r_pc;
    logic [31:0] w_instr;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_rdata;
    logic [31:0] w_next_pc;
    logic [31:0] w_wd;
    logic [4:0]  w_wa;
    logic        w_reg_we;
    logic        w_mem_we;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;

    assign w_op    = w_instr[31:26];
    assign w_rs    = w_instr[25:21];
    assign w_rt    = w_instr[20:16];
    assign w_rd    = w_instr[15:11];
    assign w_shamt = w_instr[10:6];
    assign w_funct = w_instr[5:0];
    assign w_imm   = w_instr[15:0];

    assign w_sext       = {{16{w_imm[15]}}, w_imm};
    assign w_zext       = {16'h0000, w_imm};
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_br_target  = w_pc_plus4 + {w_sext[29:0], 2'b00};
    assign w_jmp_target = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
    assign w_mem_addr   = w_rs_val + w_sext;

    single_cycle_cpu_imem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (c_IMEM_AW)
    ) INST_MEM (
        .clk     (clk),
        .i_we    (1'b0),
        .i_waddr ({c_IMEM_AW{1'b0}}),
        .i_wdata (32'd0),
        .i_raddr (r_pc[c_IMEM_AW+1:2]),
        .o_rdata (w_instr)
    );

    single_cycle_cpu_regfile REG_HEAP (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .i_we  (w_reg_we),
        .i_wa  (w_wa),
        .i_wd  (w_wd),
        .o_rd1 (w_rs_val),
        .o_rd2 (w_rt_val)
    );

    single_cycle_cpu_dmem #(
        .DEPTH (DMEM_DEPTH),
        .AW    (c_DMEM_AW)
    ) DATA_MEM (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_rt_val),
        .o_rdata (w_mem_rdata)
    );

    // Decode and execute; anything unrecognised falls through as a NOP.
    always_comb begin
        w_reg_we  = 1'b0;
        w_wa      = w_rt;
        w_wd      = 32'd0;
        w_mem_we  = 1'b0;
        w_next_pc = w_pc_plus4;
        case (w_op)
            c_OP_RTYPE: begin
                w_wa = w_rd;
                case (w_funct)
                    c_FN_ADD: begin w_reg_we = 1'b1; w_wd = w_rs_val + w_rt_val; end
                    c_FN_SUB: begin w_reg_we = 1'b1; w_wd = w_rs_val - w_rt_val; end
                    c_FN_AND: begin w_reg_we = 1'b1; w_wd = w_rs_val & w_rt_val; end
                    c_FN_OR:  begin w_reg_we = 1'b1; w_wd = w_rs_val | w_rt_val; end
                    c_FN_SLT: begin
                        w_reg_we = 1'b1;
                        w_wd     = {31'd0, ($signed(w_rs_val) < $signed(w_rt_val))};
                    end
                    c_FN_SLL: begin w_reg_we = 1'b1; w_wd = w_rt_val << w_shamt; end
`ifdef JUMP_LINK_EN
                    c_FN_JR:  w_next_pc = w_rs_val;
`endif
                    default: ;
                endcase
            end
            c_OP_ADDI: begin w_reg_we = 1'b1; w_wd = w_rs_val + w_sext; end
            c_OP_ANDI: begin w_reg_we = 1'b1; w_wd = w_rs_val & w_zext; end
            c_OP_ORI:  begin w_reg_we = 1'b1; w_wd = w_rs_val | w_zext; end
            c_OP_SLTI: begin
                w_reg_we = 1'b1;
                w_wd     = {31'd0, ($signed(w_rs_val) < $signed(w_sext))};
            end
            c_OP_LUI:  begin w_reg_we = 1'b1; w_wd = {w_imm, 16'h0000}; end
            c_OP_LW:   begin w_reg_we = 1'b1; w_wd = w_mem_rdata; end
            c_OP_SW:   w_mem_we = 1'b1;
            c_OP_BEQ:  if (w_rs_val == w_rt_val) w_next_pc = w_br_target;
            c_OP_BNE:  if (w_rs_val != w_rt_val) w_next_pc = w_br_target;
            c_OP_J:    w_next_pc = w_jmp_target;
`ifdef JUMP_LINK_EN
            c_OP_JAL: begin
                w_reg_we  = 1'b1;
                w_wa      = 5'd31;
                w_wd      = w_pc_plus4;
                w_next_pc = w_jmp_target;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_pc <= PC_RESET;
        else        r_pc <= w_next_pc;
    end
endmodule

`default_nettype wire

// File: tb/tb_single_cycle_cpu_top.sv
//==============================================================================
// Module  : tb_single_cycle_cpu_top
// Brief   : Directed self-checking bench; programs preloaded hierarchically.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_single_cycle_cpu_top;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    single_cycle_cpu_top dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset for one edge, then wipe all arrays so a program can be loaded.
    task automatic enter_reset();
        rst_n = 1'b0;
        step(1);
        for (int i = 0; i < 256; i++) begin
            dut.INST_MEM.mem[i] <= 32'h0;
            dut.DATA_MEM.mem[i] <= 32'h0;
        end
        for (int i = 0; i < 32; i++) dut.REG_HEAP.gpr[i] <= 32'h0;
    endtask

    task automatic leave_reset();
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        enter_reset();
        dut.INST_MEM.mem[0] <= enc_i(6'h08, 5'd0, 5'd7, 16'd9);
        dut.REG_HEAP.gpr[1] <= 32'd5;
        dut.DATA_MEM.mem[0] <= 32'h1234;
        step(1);
        checks++; if (dut.r_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", dut.r_pc, 32'h0); end
        checks++; if (dut.REG_HEAP.gpr[7] !== 32'h0) begin errors++; $display("FAIL reset_no_write got %h exp %h", dut.REG_HEAP.gpr[7], 32'h0); end
        checks++; if (dut.DATA_MEM.mem[0] !== 32'h1234) begin errors++; $display("FAIL reset_dmem got %h exp %h", dut.DATA_MEM.mem[0], 32'h1234); end
        rst_n = 1'b1;
        step(1);
        checks++; if (dut.r_pc !== 32'h4) begin errors++; $display("FAIL reset_pc_next got %h exp %h", dut.r_pc, 32'h4); end
        checks++; if (dut.REG_HEAP.gpr[7] !== 32'd9) begin errors++; $display("FAIL reset_first_instr got %h exp %h", dut.REG_HEAP.gpr[7], 32'd9); end
        step(3);
        rst_n = 1'b0;
        step(1);
        checks++; if (dut.r_pc !== 32'h0) begin errors++; $display("FAIL midrun_reset_pc got %h exp %h", dut.r_pc, 32'h0); end
        checks++; if (dut.REG_HEAP.gpr[1] !== 32'd5 || dut.REG_HEAP.gpr[7] !== 32'd9)
            begin errors++; $display("FAIL midrun_reset_regs got %h/%h exp %h/%h", dut.REG_HEAP.gpr[1], dut.REG_HEAP.gpr[7], 32'd5, 32'd9); end
    endtask

    task automatic test_alu();
        logic [31:0] exp_v [17];
        enter_reset();
        dut.REG_HEAP.gpr[1] <= 32'd5;
        dut.REG_HEAP.gpr[2] <= 32'd3;
        dut.INST_MEM.mem[0]  <= enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        dut.INST_MEM.mem[1]  <= enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h22);
        dut.INST_MEM.mem[2]  <= enc_r(5'd2, 5'd1, 5'd5, 5'd0, 6'h2A);
        dut.INST_MEM.mem[3]  <= enc_r(5'd0, 5'd1, 5'd8, 5'd4, 6'h00);
        dut.INST_MEM.mem[4]  <= enc_r(5'd1, 5'd2, 5'd9, 5'd0, 6'h24);
        dut.INST_MEM.mem[5]  <= enc_r(5'd1, 5'd2, 5'd10, 5'd0, 6'h25);
        dut.INST_MEM.mem[6]  <= enc_i(6'h08, 5'd1, 5'd11, 16'hFFFA);
        dut.INST_MEM.mem[7]  <= enc_i(6'h0C, 5'd11, 5'd12, 16'h8F0F);
        dut.INST_MEM.mem[8]  <= enc_i(6'h0D, 5'd0, 5'd13, 16'h8000);
        dut.INST_MEM.mem[9]  <= enc_i(6'h0A, 5'd11, 5'd14, 16'h0000);
        dut.INST_MEM.mem[10] <= enc_i(6'h0F, 5'd0, 5'd15, 16'h1234);
        dut.INST_MEM.mem[11] <= enc_r(5'd11, 5'd1, 5'd16, 5'd0, 6'h2A);
        leave_reset();
        step(12);
        exp_v[3]  = 32'd8;         exp_v[4]  = 32'd2;         exp_v[5]  = 32'd1;
        exp_v[8]  = 32'h50;        exp_v[9]  = 32'd1;         exp_v[10] = 32'd7;
        exp_v[11] = 32'hFFFF_FFFF; exp_v[12] = 32'h0000_8F0F; exp_v[13] = 32'h0000_8000;
        exp_v[14] = 32'd1;         exp_v[15] = 32'h1234_0000; exp_v[16] = 32'd1;
        for (int r = 3; r <= 16; r++) begin
            if (r == 6 || r == 7) continue;
            checks++;
            if (dut.REG_HEAP.gpr[r] !== exp_v[r]) begin
                errors++;
                $display("FAIL alu_gpr%0d got %h exp %h", r, dut.REG_HEAP.gpr[r], exp_v[r]);
            end
        end
        checks++; if (dut.r_pc !== 32'h30) begin errors++; $display("FAIL alu_pc got %h exp %h", dut.r_pc, 32'h30); end
    endtask

    task automatic test_memory();
        enter_reset();
        dut.DATA_MEM.mem[1] <= 32'hA5;
        dut.INST_MEM.mem[0] <= enc_i(6'h23, 5'd0, 5'd6, 16'h0004);
        dut.INST_MEM.mem[1] <= enc_i(6'h2B, 5'd0, 5'd6, 16'h0008);
        dut.INST_MEM.mem[2] <= enc_i(6'h23, 5'd0, 5'd18, 16'h0404);
        dut.INST_MEM.mem[3] <= enc_i(6'h08, 5'd0, 5'd19, 16'd12);
        dut.INST_MEM.mem[4] <= enc_i(6'h23, 5'd19, 5'd20, 16'hFFF8);
        dut.INST_MEM.mem[5] <= enc_i(6'h2B, 5'd0, 5'd19, 16'h000E);
        dut.INST_MEM.mem[6] <= enc_i(6'h23, 5'd0, 5'd23, 16'h0008);
        leave_reset();
        step(7);
        checks++; if (dut.REG_HEAP.gpr[6] !== 32'hA5) begin errors++; $display("FAIL mem_lw got %h exp %h", dut.REG_HEAP.gpr[6], 32'hA5); end
        checks++; if (dut.DATA_MEM.mem[2] !== 32'hA5) begin errors++; $display("FAIL mem_sw got %h exp %h", dut.DATA_MEM.mem[2], 32'hA5); end
        checks++; if (dut.REG_HEAP.gpr[18] !== 32'hA5) begin errors++; $display("FAIL mem_wrap got %h exp %h", dut.REG_HEAP.gpr[18], 32'hA5); end
        checks++; if (dut.REG_HEAP.gpr[20] !== 32'hA5) begin errors++; $display("FAIL mem_neg_off got %h exp %h", dut.REG_HEAP.gpr[20], 32'hA5); end
        checks++; if (dut.DATA_MEM.mem[3] !== 32'd12) begin errors++; $display("FAIL mem_unaligned got %h exp %h", dut.DATA_MEM.mem[3], 32'd12); end
        checks++; if (dut.REG_HEAP.gpr[23] !== 32'hA5) begin errors++; $display("FAIL mem_readback got %h exp %h", dut.REG_HEAP.gpr[23], 32'hA5); end
    endtask

    task automatic test_branch_jump();
        logic [31:0] exp_pc [7];
        enter_reset();
        dut.INST_MEM.mem[0] <= enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        dut.INST_MEM.mem[1] <= enc_i(6'h08, 5'd0, 5'd21, 16'd1);
        dut.INST_MEM.mem[2] <= enc_i(6'h08, 5'd0, 5'd21, 16'd2);
        dut.INST_MEM.mem[3] <= enc_i(6'h05, 5'd0, 5'd0, 16'd5);
        dut.INST_MEM.mem[4] <= enc_i(6'h08, 5'd0, 5'd22, 16'd3);
        dut.INST_MEM.mem[5] <= enc_i(6'h04, 5'd22, 5'd0, 16'd1);
        dut.INST_MEM.mem[6] <= enc_i(6'h05, 5'd22, 5'd0, 16'd1);
        dut.INST_MEM.mem[7] <= enc_i(6'h08, 5'd0, 5'd21, 16'd5);
        dut.INST_MEM.mem[8] <= enc_j(6'h02, 26'd0);
        leave_reset();
        exp_pc[0] = 32'h0C; exp_pc[1] = 32'h10; exp_pc[2] = 32'h14; exp_pc[3] = 32'h18;
        exp_pc[4] = 32'h20; exp_pc[5] = 32'h00; exp_pc[6] = 32'h0C;
        for (int k = 0; k < 7; k++) begin
            step(1);
            checks++;
            if (dut.r_pc !== exp_pc[k]) begin
                errors++;
                $display("FAIL br_trace%0d got %h exp %h", k, dut.r_pc, exp_pc[k]);
            end
        end
        checks++; if (dut.REG_HEAP.gpr[21] !== 32'h0) begin errors++; $display("FAIL br_skipped got %h exp %h", dut.REG_HEAP.gpr[21], 32'h0); end
        checks++; if (dut.REG_HEAP.gpr[22] !== 32'd3) begin errors++; $display("FAIL br_fallthru got %h exp %h", dut.REG_HEAP.gpr[22], 32'd3); end
    endtask

    task automatic test_zero_unknown();
        enter_reset();
        dut.REG_HEAP.gpr[1]  <= 32'h77;
        dut.REG_HEAP.gpr[2]  <= 32'h11;
        dut.DATA_MEM.mem[29] <= 32'h5555;
        dut.INST_MEM.mem[0] <= enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        dut.INST_MEM.mem[1] <= enc_r(5'd1, 5'd2, 5'd0, 5'd0, 6'h20);
        dut.INST_MEM.mem[2] <= enc_i(6'h3F, 5'd1, 5'd1, 16'hFFFF);
        dut.INST_MEM.mem[3] <= enc_r(5'd1, 5'd2, 5'd1, 5'd0, 6'h3F);
        dut.INST_MEM.mem[4] <= enc_j(6'h02, 26'h100);
        leave_reset();
        step(2);
        checks++; if (dut.REG_HEAP.gpr[0] !== 32'h0) begin errors++; $display("FAIL zero_reg got %h exp %h", dut.REG_HEAP.gpr[0], 32'h0); end
        step(1);
        checks++; if (dut.r_pc !== 32'h0C) begin errors++; $display("FAIL unk_op_pc got %h exp %h", dut.r_pc, 32'h0C); end
        checks++; if (dut.REG_HEAP.gpr[1] !== 32'h77 || dut.DATA_MEM.mem[29] !== 32'h5555)
            begin errors++; $display("FAIL unk_op_state got %h/%h exp %h/%h", dut.REG_HEAP.gpr[1], dut.DATA_MEM.mem[29], 32'h77, 32'h5555); end
        step(1);
        checks++; if (dut.REG_HEAP.gpr[1] !== 32'h77) begin errors++; $display("FAIL unk_funct got %h exp %h", dut.REG_HEAP.gpr[1], 32'h77); end
        step(1);
        checks++; if (dut.r_pc !== 32'h400) begin errors++; $display("FAIL jump_far got %h exp %h", dut.r_pc, 32'h400); end
        step(1);
        checks++; if (dut.r_pc !== 32'h404) begin errors++; $display("FAIL fetch_wrap got %h exp %h", dut.r_pc, 32'h404); end
        checks++; if (dut.REG_HEAP.gpr[0] !== 32'h0) begin errors++; $display("FAIL zero_reg_wrap got %h exp %h", dut.REG_HEAP.gpr[0], 32'h0); end
    endtask

    task automatic test_jump_link();
        logic [31:0] exp_pc5, exp_pc6, exp_r31;
`ifdef JUMP_LINK_EN
        exp_pc5 = 32'h20; exp_pc6 = 32'h14; exp_r31 = 32'h14;
`else
        exp_pc5 = 32'h14; exp_pc6 = 32'h18; exp_r31 = 32'hDEAD_BEEF;
`endif
        enter_reset();
        dut.REG_HEAP.gpr[31] <= 32'hDEAD_BEEF;
        dut.INST_MEM.mem[4] <= enc_j(6'h03, 26'h8);
        dut.INST_MEM.mem[5] <= enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        dut.INST_MEM.mem[8] <= enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        leave_reset();
        step(4);
        checks++; if (dut.r_pc !== 32'h10) begin errors++; $display("FAIL jl_reach got %h exp %h", dut.r_pc, 32'h10); end
        step(1);
        checks++; if (dut.r_pc !== exp_pc5) begin errors++; $display("FAIL jal_pc got %h exp %h", dut.r_pc, exp_pc5); end
        checks++; if (dut.REG_HEAP.gpr[31] !== exp_r31) begin errors++; $display("FAIL jal_link got %h exp %h", dut.REG_HEAP.gpr[31], exp_r31); end
        step(1);
        checks++; if (dut.r_pc !== exp_pc6) begin errors++; $display("FAIL jr_pc got %h exp %h", dut.r_pc, exp_pc6); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        test_reset();
        test_alu();
        test_memory();
        test_branch_jump();
        test_zero_unknown();
        test_jump_link();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
